// File: rtl/button_repeat.sv
// button_repeat: turns a debounced button level into press and auto-repeat pulses.
// Define BUTTON_RELEASE_PULSE_EN to add a release_pulse output on release from a hold.
module button_repeat #(
  parameter int DELAY_CYCLES  = 937500,
  parameter int PERIOD_CYCLES = 312500,
  parameter int CNT_W         = 20,
  parameter int RPT_W         = 8
) (
  input  logic             vclk,
  input  logic             rst,
  input  logic             en,
  input  logic             debounced_button,
  output logic             press,
  output logic             repeat_pulse,
  output logic             move,
  output logic             held,
`ifdef BUTTON_RELEASE_PULSE_EN
  output logic             release_pulse,
`endif
  output logic [RPT_W-1:0] rpt_cnt
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PERIOD_CYCLES - 1);
  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             btn_q;
  logic             rise;
  logic             last;
  logic [RPT_W-1:0] rpt_next;
  always_comb begin
    rise     = debounced_button & ~btn_q;
    last     = (state == DELAY) ? (timer == D_LAST) : (timer == P_LAST);
    rpt_next = (&rpt_cnt) ? rpt_cnt : rpt_cnt + 1'b1;
  end
  // Priority: en abort, then release, then timer expiry.
  always_ff @(posedge vclk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      timer        <= '0;
      btn_q        <= 1'b0;
      rpt_cnt      <= '0;
      press        <= 1'b0;
      repeat_pulse <= 1'b0;
      move         <= 1'b0;
      held         <= 1'b0;
`ifdef BUTTON_RELEASE_PULSE_EN
      release_pulse <= 1'b0;
`endif
    end else begin
      btn_q        <= debounced_button;
      press        <= 1'b0;
      repeat_pulse <= 1'b0;
      move         <= 1'b0;
`ifdef BUTTON_RELEASE_PULSE_EN
      release_pulse <= 1'b0;
`endif
      if (!en) begin
        state <= IDLE;
        timer <= '0;
        held  <= 1'b0;
      end else if (state == IDLE) begin
        if (rise) begin
          press   <= 1'b1;
          move    <= 1'b1;
          timer   <= '0;
          rpt_cnt <= '0;
          state   <= DELAY;
          held    <= 1'b1;
        end
      end else if (state != DELAY && state != REPEAT) begin
        state <= IDLE;
        timer <= '0;
        held  <= 1'b0;
      end else if (!debounced_button) begin
        state <= IDLE;
        timer <= '0;
        held  <= 1'b0;
`ifdef BUTTON_RELEASE_PULSE_EN
        release_pulse <= btn_q;
`endif
      end else if (last) begin
        repeat_pulse <= 1'b1;
        move         <= 1'b1;
        timer        <= '0;
        rpt_cnt      <= rpt_next;
        state        <= REPEAT;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_button_repeat.sv
// tb_button_repeat: scoreboard bench; stimulus queues expected pulses, a monitor pops and checks them.
module tb_button_repeat;
  localparam int RPT_W = 3;
  typedef struct {
    int kind;
    int cyc;
    int rpt;
  } ev_t;
  logic             vclk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b1;
  logic             btn = 1'b1;
  logic             press;
  logic             repeat_pulse;
  logic             move;
  logic             held;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rel;
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  ev_t              q[$];
  logic             prev_move = 1'b0;

  button_repeat #(
    .DELAY_CYCLES(10),
    .PERIOD_CYCLES(4),
    .CNT_W(8),
    .RPT_W(RPT_W)
  ) dut (
    .vclk(vclk),
    .rst(rst),
    .en(en),
    .debounced_button(btn),
    .press(press),
    .repeat_pulse(repeat_pulse),
    .move(move),
    .held(held),
`ifdef BUTTON_RELEASE_PULSE_EN
    .release_pulse(rel),
`endif
    .rpt_cnt(rpt_cnt)
  );
`ifndef BUTTON_RELEASE_PULSE_EN
  assign rel = 1'b0;
`endif

  always #5 vclk = ~vclk;
  always @(posedge vclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input int r);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.rpt  = r;
    q.push_back(e);
  endtask

  task automatic push_rel(input int c, input int r);
`ifdef BUTTON_RELEASE_PULSE_EN
    push(2, c, r);
`endif
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge vclk);
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge vclk) begin
    if (rst) begin
      if (press || repeat_pulse || rel) begin
        chk("press_and_repeat_exclusive", int'(press & repeat_pulse), 0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse at cyc %0d: press %0b repeat %0b release %0b, none expected", cyc, press, repeat_pulse, rel);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("pulse_kind", press ? 0 : (repeat_pulse ? 1 : 2), e.kind);
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_rpt_cnt", int'(rpt_cnt), e.rpt);
        end
      end
      chk("move_is_or", int'(move), int'(press | repeat_pulse));
      if (move) chk("move_not_consecutive", int'(prev_move), 0);
      prev_move <= move;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    #2 rst = 1'b0;
    repeat (3) begin
      @(negedge vclk);
      chk("reset_outputs", int'({press, repeat_pulse, move, held, rel, rpt_cnt}), 0);
    end
    // Button held through reset: first edge after release is a press.
    rst = 1'b0;
    p = cyc + 1;
    push(0, p, 0);
    for (int i = 0; i < 8; i++) push(1, p + 10 + 4 * i, (i < 7) ? i + 1 : 7);
    push_rel(p + 41, 7);
    rst = 1'b1;
    @(negedge vclk);
    chk("held_after_press", int'(held), 1);
    to_cyc(p + 40);
    btn = 1'b0;
    to_cyc(p + 43);
    chk("held_after_release", int'(held), 0);
    chk("rpt_cnt_held_saturated", int'(rpt_cnt), 7);
    // Release on the edge where the delay timer matches.
    btn = 1'b1;
    p = cyc + 1;
    push(0, p, 0);
    push_rel(p + 10, 0);
    to_cyc(p + 9);
    btn = 1'b0;
    to_cyc(p + 10);
    chk("release_wins_no_repeat", int'(repeat_pulse), 0);
    chk("release_wins_held", int'(held), 0);
    to_cyc(p + 12);
    // en dropped mid-REPEAT; no press on restore while still held.
    btn = 1'b1;
    p = cyc + 1;
    push(0, p, 0);
    push(1, p + 10, 1);
    push(1, p + 14, 2);
    to_cyc(p + 15);
    en = 1'b0;
    to_cyc(p + 16);
    chk("en_off_held", int'(held), 0);
    to_cyc(p + 18);
    chk("en_off_held_late", int'(held), 0);
    en = 1'b1;
    to_cyc(p + 25);
    chk("en_restore_no_press", int'(held), 0);
    btn = 1'b0;
    push(0, p + 28, 0);
    push_rel(p + 30, 0);
    to_cyc(p + 27);
    btn = 1'b1;
    to_cyc(p + 29);
    btn = 1'b0;
    to_cyc(p + 33);
    // 1,0,1 with a one-cycle gap gives two presses two cycles apart.
    p = cyc;
    push(0, p + 1, 0);
    push_rel(p + 2, 0);
    push(0, p + 3, 0);
    push_rel(p + 6, 0);
    btn = 1'b1;
    to_cyc(p + 1);
    btn = 1'b0;
    to_cyc(p + 2);
    btn = 1'b1;
    to_cyc(p + 5);
    btn = 1'b0;
    to_cyc(p + 9);
`ifdef BUTTON_RELEASE_PULSE_EN
    // Release pulse after a hold, and none after an en-forced abort.
    btn = 1'b1;
    p = cyc + 1;
    push(0, p, 0);
    push(1, p + 10, 1);
    push(1, p + 14, 2);
    push(2, p + 16, 2);
    to_cyc(p + 15);
    btn = 1'b0;
    to_cyc(p + 20);
    btn = 1'b1;
    p = cyc + 1;
    push(0, p, 0);
    push(1, p + 10, 1);
    push(1, p + 14, 2);
    to_cyc(p + 15);
    en = 1'b0;
    to_cyc(p + 16);
    btn = 1'b0;
    to_cyc(p + 18);
    en = 1'b1;
    to_cyc(p + 22);
`endif
    repeat (5) @(negedge vclk);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
